// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit_if
//  Description : Bundle of pipeline-register taps and control outputs that
//                connect the forwarding / load-use hazard unit to the core.
//                The master side is the pipeline: it drives the stage
//                register fields and receives the forwarding selects, the
//                stall controls and the hazard statistics. The slave side
//                is the hazard unit itself.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_RS          number of source-operand ports (1..4)
//    REG_AW          register-index width
//  Signals (direction seen from the hazard unit / slave)
//    idex_rs         in   NUM_RS*REG_AW  EX-stage source indices
//    idex_rs_used    in   NUM_RS         EX-stage port reads a register
//    exmem_rd        in   REG_AW         EX/MEM destination
//    exmem_regwrite  in   1              EX/MEM writes rd
//    exmem_memtoreg  in   1              EX/MEM instruction is a load
//    memwb_rd        in   REG_AW         MEM/WB destination
//    memwb_regwrite  in   1              MEM/WB writes rd
//    ifid_rs         in   NUM_RS*REG_AW  ID-stage source indices
//    ifid_rs_used    in   NUM_RS         ID-stage port reads a register
//    idex_rd         in   REG_AW         ID/EX destination
//    idex_memread    in   1              ID/EX instruction is a load
//    flush           in   1              redirect/trap flush
//    fwd_sel         out  2*NUM_RS       per-port operand mux select
//    pc_hold         out  1              hold PC
//    ifid_hold       out  1              hold IF/ID
//    idex_bubble     out  1              load NOP into ID/EX
//    fwd_err         out  1              EX operand depends on load in EX/MEM
//    stall_cycles    out  16             stall-cycle statistic
//    lu_events       out  16             load-use event statistic
// ============================================================================
interface fwd_hazard_unit_if #(
  parameter int NUM_RS = 2,
  parameter int REG_AW = 5
);

  // EX-stage forwarding inputs
  logic [NUM_RS*REG_AW-1:0] idex_rs;
  logic [NUM_RS-1:0]        idex_rs_used;
  logic [REG_AW-1:0]        exmem_rd;
  logic                     exmem_regwrite;
  logic                     exmem_memtoreg;
  logic [REG_AW-1:0]        memwb_rd;
  logic                     memwb_regwrite;

  // ID-stage load-use inputs
  logic [NUM_RS*REG_AW-1:0] ifid_rs;
  logic [NUM_RS-1:0]        ifid_rs_used;
  logic [REG_AW-1:0]        idex_rd;
  logic                     idex_memread;
  logic                     flush;

  // Outputs of the hazard unit
  logic [2*NUM_RS-1:0]      fwd_sel;
  logic                     pc_hold;
  logic                     ifid_hold;
  logic                     idex_bubble;
  logic                     fwd_err;
  logic [15:0]              stall_cycles;
  logic [15:0]              lu_events;

  // Pipeline side
  modport master (
    output idex_rs, idex_rs_used, exmem_rd, exmem_regwrite, exmem_memtoreg,
           memwb_rd, memwb_regwrite, ifid_rs, ifid_rs_used, idex_rd,
           idex_memread, flush,
    input  fwd_sel, pc_hold, ifid_hold, idex_bubble, fwd_err,
           stall_cycles, lu_events
  );

  // Hazard unit side
  modport slave (
    input  idex_rs, idex_rs_used, exmem_rd, exmem_regwrite, exmem_memtoreg,
           memwb_rd, memwb_regwrite, ifid_rs, ifid_rs_used, idex_rd,
           idex_memread, flush,
    output fwd_sel, pc_hold, ifid_hold, idex_bubble, fwd_err,
           stall_cycles, lu_events
  );

endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Operand forwarding and load-use hazard control for the
//                5-stage RISC-V pipeline. Forwarding is generalised to
//                NUM_RS source ports; a load-use hazard in ID inserts exactly
//                LOAD_LAT bubbles using a small IDLE/STALL machine with a
//                3-bit down-counter.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_RS    2  source-operand ports forwarded / checked (1..4)
//    REG_AW    5  register-index width (x0 never forwarded or stalled on)
//    LOAD_LAT  1  bubbles inserted per load-use hazard (1..7)
//  Ports
//    clk       in   rising-edge clock
//    rst_n     in   asynchronous active-low reset
//    hz        slave modport of fwd_hazard_unit_if (all pipeline taps and
//              control outputs, see the interface header)
//  Build option
//    HAZ_STATS_EN  when defined, builds the saturating 16-bit stall_cycles
//                  and lu_events statistics counters; otherwise both read 0.
// ============================================================================
module fwd_hazard_unit #(
  parameter int NUM_RS   = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  fwd_hazard_unit_if.slave hz
);

  localparam logic [REG_AW-1:0] REG_ZERO     = '0;
  // First bubble is issued from IDLE, so STALL covers the remaining
  // LOAD_LAT-1 cycles: counter starts at LOAD_LAT-2 and exits on zero.
  localparam logic [2:0]        CNT_INIT     = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;
  localparam bit                MULTI_BUBBLE = (LOAD_LAT > 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       stall;
  logic       lu_det;

  // --------------------------------------------------------------------------
  // Forwarding: one selector per source port, purely combinational.
  // --------------------------------------------------------------------------
  wire [2*NUM_RS-1:0] fwd_sel_w;
  wire [NUM_RS-1:0]   fwd_err_w;
  wire [NUM_RS-1:0]   lu_hit_w;

  generate
    for (genvar i = 0; i < NUM_RS; i++) begin : g_port
      wire [REG_AW-1:0] ex_rs = hz.idex_rs[i*REG_AW +: REG_AW];
      wire [REG_AW-1:0] id_rs = hz.ifid_rs[i*REG_AW +: REG_AW];

      wire mx = hz.idex_rs_used[i] && hz.exmem_regwrite &&
                (hz.exmem_rd != REG_ZERO) && (hz.exmem_rd == ex_rs);
      wire mw = hz.idex_rs_used[i] && hz.memwb_regwrite &&
                (hz.memwb_rd != REG_ZERO) && (hz.memwb_rd == ex_rs);

      // A match in EX/MEM always shadows MEM/WB since it is the younger
      // writer. A load in EX/MEM has no data yet: select the regfile and
      // flag it, because the stall logic should have prevented this.
      assign fwd_sel_w[2*i +: 2] = (mx && !hz.exmem_memtoreg) ? 2'b10 :
                                   (!mx && mw)                ? 2'b01 :
                                                                2'b00;
      assign fwd_err_w[i] = mx && hz.exmem_memtoreg;

      // ID-stage consumer of the load currently in ID/EX
      assign lu_hit_w[i] = hz.ifid_rs_used[i] && (id_rs == hz.idex_rd);
    end
  endgenerate

  assign hz.fwd_sel = fwd_sel_w;
  assign hz.fwd_err = |fwd_err_w;

  assign lu_det = hz.idex_memread && (hz.idex_rd != REG_ZERO) && (|lu_hit_w);

  // --------------------------------------------------------------------------
  // Load-use stall machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;

    if (hz.flush) begin
      // Flush kills the stalled instruction: abandon remaining bubbles.
      state_nxt = IDLE;
      cnt_nxt   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (lu_det) begin
            stall = 1'b1;
            if (MULTI_BUBBLE) begin
              state_nxt = STALL;
              cnt_nxt   = CNT_INIT;
            end
          end
        end
        STALL: begin
          // The dependent instruction is frozen in IF/ID; lu_det would see
          // the bubbles, so it is deliberately not consulted here.
          stall = 1'b1;
          if (cnt == 3'd0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // The state register resets asynchronously, so these drop as soon as
  // rst_n falls even in the middle of a stall.
  assign hz.pc_hold     = stall;
  assign hz.ifid_hold   = stall;
  assign hz.idex_bubble = stall;

  // --------------------------------------------------------------------------
  // Hazard statistics
  // --------------------------------------------------------------------------
`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] lu_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
      lu_cnt_q    <= 16'h0000;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      // Only the IDLE-issued first bubble marks a new event.
      if ((state == IDLE) && lu_det && !hz.flush && (lu_cnt_q != 16'hFFFF)) begin
        lu_cnt_q <= lu_cnt_q + 16'd1;
      end
    end
  end

  assign hz.stall_cycles = stall_cnt_q;
  assign hz.lu_events    = lu_cnt_q;
`else
  assign hz.stall_cycles = 16'h0000;
  assign hz.lu_events    = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Self-checking bench for fwd_hazard_unit. Two instances are
//                built: dut1 with LOAD_LAT=1 and dut3 with LOAD_LAT=3. A
//                table of directed vectors covers forwarding and single-cycle
//                load-use detection; hand-written sequences cover multi-
//                bubble stalls, flush and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_unit;

`ifdef HAZ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;

  int total;
  int passed;

  fwd_hazard_unit_if #(.NUM_RS(2), .REG_AW(5)) if1 ();
  fwd_hazard_unit_if #(.NUM_RS(2), .REG_AW(5)) if3 ();

  fwd_hazard_unit #(.NUM_RS(2), .REG_AW(5), .LOAD_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if1.slave)
  );

  fwd_hazard_unit #(.NUM_RS(2), .REG_AW(5), .LOAD_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] rs;
    logic [1:0] used;
    logic [4:0] exmem_rd;
    logic       exmem_rw;
    logic       exmem_m2r;
    logic [4:0] memwb_rd;
    logic       memwb_rw;
    logic [4:0] ld_rd;
    logic       ld_memread;
    logic [9:0] ifid_rs;
    logic [1:0] ifid_used;
    logic [3:0] exp_sel;
    logic       exp_err;
    logic       exp_hold;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic clear_inputs();
    if1.idex_rs = '0; if1.idex_rs_used = '0; if1.exmem_rd = '0;
    if1.exmem_regwrite = 1'b0; if1.exmem_memtoreg = 1'b0;
    if1.memwb_rd = '0; if1.memwb_regwrite = 1'b0; if1.ifid_rs = '0;
    if1.ifid_rs_used = '0; if1.idex_rd = '0; if1.idex_memread = 1'b0;
    if1.flush = 1'b0;
    if3.idex_rs = '0; if3.idex_rs_used = '0; if3.exmem_rd = '0;
    if3.exmem_regwrite = 1'b0; if3.exmem_memtoreg = 1'b0;
    if3.memwb_rd = '0; if3.memwb_regwrite = 1'b0; if3.ifid_rs = '0;
    if3.ifid_rs_used = '0; if3.idex_rd = '0; if3.idex_memread = 1'b0;
    if3.flush = 1'b0;
  endtask

  // ID-stage hazard: load to x3 in ID/EX, ID rs1 reads x3
  task automatic hazard1(input logic on);
    if1.idex_memread = on; if1.idex_rd = on ? 5'd3 : 5'd0;
    if1.ifid_rs = on ? {5'd3, 5'd0} : 10'd0; if1.ifid_rs_used = on ? 2'b10 : 2'b00;
  endtask

  task automatic hazard3(input logic on);
    if3.idex_memread = on; if3.idex_rd = on ? 5'd3 : 5'd0;
    if3.ifid_rs = on ? {5'd3, 5'd0} : 10'd0; if3.ifid_rs_used = on ? 2'b10 : 2'b00;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_stall3(input string nm, input logic exp);
    chk({nm, " pc_hold"},     {31'd0, if3.pc_hold},     {31'd0, exp});
    chk({nm, " ifid_hold"},   {31'd0, if3.ifid_hold},   {31'd0, exp});
    chk({nm, " idex_bubble"}, {31'd0, if3.idex_bubble}, {31'd0, exp});
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    clear_inputs();

    //                rs             used   exrd  rw  m2r wbrd  rw  ldrd ld  ifid_rs        iu     sel     err  hold
    vecs[0] = '{{5'd0, 5'd5}, 2'b11, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0,  1'b0, 10'd0,          2'b00, 4'b0010, 1'b0, 1'b0};
    vecs[1] = '{{5'd0, 5'd0}, 2'b11, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd3,  1'b1, {5'd3, 5'd0},  2'b10, 4'b0000, 1'b0, 1'b1};
    vecs[2] = '{{5'd7, 5'd0}, 2'b11, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0,  1'b1, 10'd0,          2'b11, 4'b0100, 1'b0, 1'b0};
    vecs[3] = '{{5'd0, 5'd9}, 2'b11, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 5'd3,  1'b1, {5'd3, 5'd2},  2'b01, 4'b0000, 1'b1, 1'b0};
    vecs[4] = '{{5'd0, 5'd6}, 2'b00, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, {5'd0, 5'd12}, 2'b01, 4'b0000, 1'b0, 1'b1};
    vecs[5] = '{{5'd6, 5'd6}, 2'b11, 5'd6, 1'b0, 1'b0, 5'd6, 1'b1, 5'd12, 1'b0, {5'd0, 5'd12}, 2'b01, 4'b0101, 1'b0, 1'b0};
    vecs[6] = '{{5'd8, 5'd4}, 2'b11, 5'd4, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0,  1'b0, 10'd0,          2'b00, 4'b0110, 1'b0, 1'b0};
    vecs[7] = '{{5'd9, 5'd8}, 2'b11, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 5'd0,  1'b0, 10'd0,          2'b00, 4'b0001, 1'b1, 1'b0};

    // Reset state
    #3;
    chk("reset pc_hold dut1",    {31'd0, if1.pc_hold},  32'd0);
    chk("reset pc_hold dut3",    {31'd0, if3.pc_hold},  32'd0);
    chk("reset fwd_sel",         {28'd0, if1.fwd_sel},  32'd0);
    chk("reset stall_cycles",    {16'd0, if3.stall_cycles}, 32'd0);
    chk("reset lu_events",       {16'd0, if3.lu_events},    32'd0);
    #9;
    rst_n = 1'b1;

    // Table: forwarding and IDLE load-use detection on dut1
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if1.idex_rs = vecs[i].rs;             if1.idex_rs_used = vecs[i].used;
      if1.exmem_rd = vecs[i].exmem_rd;      if1.exmem_regwrite = vecs[i].exmem_rw;
      if1.exmem_memtoreg = vecs[i].exmem_m2r;
      if1.memwb_rd = vecs[i].memwb_rd;      if1.memwb_regwrite = vecs[i].memwb_rw;
      if1.idex_rd = vecs[i].ld_rd;          if1.idex_memread = vecs[i].ld_memread;
      if1.ifid_rs = vecs[i].ifid_rs;        if1.ifid_rs_used = vecs[i].ifid_used;
      @(negedge clk);
      chk($sformatf("vec%0d fwd_sel", i),     {28'd0, if1.fwd_sel},     {28'd0, vecs[i].exp_sel});
      chk($sformatf("vec%0d fwd_err", i),     {31'd0, if1.fwd_err},     {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d pc_hold", i),     {31'd0, if1.pc_hold},     {31'd0, vecs[i].exp_hold});
      chk($sformatf("vec%0d idex_bubble", i), {31'd0, if1.idex_bubble}, {31'd0, vecs[i].exp_hold});
    end

    // LOAD_LAT=1: single bubble, then release
    pulse_reset();
    @(posedge clk); #1; hazard1(1'b1);
    @(negedge clk);
    chk("lat1 c0 pc_hold",   {31'd0, if1.pc_hold},   32'd1);
    chk("lat1 c0 ifid_hold", {31'd0, if1.ifid_hold}, 32'd1);
    @(posedge clk); #1; hazard1(1'b0);
    @(negedge clk);
    chk("lat1 c1 pc_hold",   {31'd0, if1.pc_hold},   32'd0);
    chk("lat1 lu_events",    {16'd0, if1.lu_events},    STATS ? 32'd1 : 32'd0);
    chk("lat1 stall_cycles", {16'd0, if1.stall_cycles}, STATS ? 32'd1 : 32'd0);
    // Flush suppresses a hazard detected in IDLE
    @(posedge clk); #1; hazard1(1'b1); if1.flush = 1'b1;
    @(negedge clk);
    chk("lat1 flush pc_hold", {31'd0, if1.pc_hold}, 32'd0);
    @(posedge clk); #1; hazard1(1'b0); if1.flush = 1'b0;
    @(negedge clk);
    chk("lat1 flush lu_events", {16'd0, if1.lu_events}, STATS ? 32'd1 : 32'd0);

    // LOAD_LAT=3: exactly three bubbles
    pulse_reset();
    @(posedge clk); #1; hazard3(1'b1);
    @(negedge clk); chk_stall3("lat3 c0", 1'b1);
    @(posedge clk); #1; hazard3(1'b0);
    @(negedge clk); chk_stall3("lat3 c1", 1'b1);
    @(negedge clk); chk_stall3("lat3 c2", 1'b1);
    @(negedge clk); chk_stall3("lat3 c3", 1'b0);
    @(negedge clk); chk_stall3("lat3 c4", 1'b0);
    chk("lat3 stall_cycles", {16'd0, if3.stall_cycles}, STATS ? 32'd3 : 32'd0);
    chk("lat3 lu_events",    {16'd0, if3.lu_events},    STATS ? 32'd1 : 32'd0);

    // LOAD_LAT=3: flush in the second stall cycle
    pulse_reset();
    @(posedge clk); #1; hazard3(1'b1);
    @(negedge clk); chk_stall3("flush c0", 1'b1);
    @(posedge clk); #1; hazard3(1'b0); if3.flush = 1'b1;
    @(negedge clk); chk_stall3("flush c1", 1'b0);
    @(posedge clk); #1; if3.flush = 1'b0;
    @(negedge clk); chk_stall3("flush c2", 1'b0);
    @(negedge clk); chk_stall3("flush c3", 1'b0);
    chk("flush stall_cycles", {16'd0, if3.stall_cycles}, STATS ? 32'd1 : 32'd0);

    // LOAD_LAT=3: asynchronous reset in the second stall cycle
    pulse_reset();
    @(posedge clk); #1; hazard3(1'b1);
    @(negedge clk); chk_stall3("arst c0", 1'b1);
    @(posedge clk); #1; hazard3(1'b0);
    @(negedge clk); chk_stall3("arst c1", 1'b1);
    #1; rst_n = 1'b0;
    #1; chk_stall3("arst during", 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk_stall3("arst after1", 1'b0);
    @(negedge clk); chk_stall3("arst after2", 1'b0);
    chk("arst stall_cycles", {16'd0, if3.stall_cycles}, 32'd0);
    // A fresh hazard after reset still stalls
    @(posedge clk); #1; hazard3(1'b1);
    @(negedge clk); chk_stall3("arst new", 1'b1);
    @(posedge clk); #1; hazard3(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
